// File: rtl/seven_seg_display.sv
// Four-digit multiplexed 7-segment driver: picks one BCD digit per cycle,
// decodes it to active-high segments plus decimal point, and drives a
// one-hot digit strobe. Both outputs are registered (1-cycle latency).
module seven_seg_display (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [1:0] i_Select,
    input  logic [3:0] i_Enable_Digits,
    input  logic       i_Enable_Dot,
    input  logic [3:0] i_Data_Dig1,
    input  logic [3:0] i_Data_Dig2,
    input  logic [3:0] i_Data_Dig3,
    input  logic [3:0] i_Data_Dig4,
    output logic [7:0] o_Segments,
    output logic [3:0] o_Digits
);

    logic [3:0] data_sel;
    logic       dig_en;
    logic [6:0] seg_pat;
    logic [7:0] segments_d, segments_q;
    logic [3:0] digits_d,   digits_q;

    // Route the selected digit's data and its enable bit (enable vector is
    // MSB-first: bit3 belongs to digit1).
    always_comb begin
        data_sel = i_Data_Dig1;
        dig_en   = i_Enable_Digits[3];
        case (i_Select)
            2'd0: begin data_sel = i_Data_Dig1; dig_en = i_Enable_Digits[3]; end
            2'd1: begin data_sel = i_Data_Dig2; dig_en = i_Enable_Digits[2]; end
            2'd2: begin data_sel = i_Data_Dig3; dig_en = i_Enable_Digits[1]; end
            default: begin data_sel = i_Data_Dig4; dig_en = i_Enable_Digits[0]; end
        endcase
    end

    // BCD to segment pattern (g..a); non-BCD codes blank the digit.
    always_comb begin
        seg_pat = 7'b0000000;
        case (data_sel)
            4'd0: seg_pat = 7'b0111111;
            4'd1: seg_pat = 7'b0000110;
            4'd2: seg_pat = 7'b1011011;
            4'd3: seg_pat = 7'b1001111;
            4'd4: seg_pat = 7'b1100110;
            4'd5: seg_pat = 7'b1101101;
            4'd6: seg_pat = 7'b1111101;
            4'd7: seg_pat = 7'b0000111;
            4'd8: seg_pat = 7'b1111111;
            4'd9: seg_pat = 7'b1101111;
            default: seg_pat = 7'b0000000;
        endcase
    end

    // Next output values: everything dark when the selected digit is off;
    // the dot only ever lights on digit2 (hours/minutes separator).
    always_comb begin
        segments_d = 8'h00;
        digits_d   = 4'b0000;
        if (dig_en) begin
            segments_d = {i_Enable_Dot && (i_Select == 2'd1), seg_pat};
            digits_d   = 4'b0001 << i_Select;
        end
    end

    // Output registers; reset blanks the display and overrides all inputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            segments_q <= 8'h00;
            digits_q   <= 4'b0000;
        end else begin
            segments_q <= segments_d;
            digits_q   <= digits_d;
        end
    end

    assign o_Segments = segments_q;
    assign o_Digits   = digits_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Bench for seven_seg_display: directed cases with literal expectations plus
// randomized stimulus checked against a table-driven reference model.
module tb_seven_seg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] en;
    logic       dot;
    logic [3:0] d1, d2, d3, d4;
    logic [7:0] seg;
    logic [3:0] dig;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] PAT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    seven_seg_display dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_Select        (sel),
        .i_Enable_Digits (en),
        .i_Enable_Dot    (dot),
        .i_Data_Dig1     (d1),
        .i_Data_Dig2     (d2),
        .i_Data_Dig3     (d3),
        .i_Data_Dig4     (d4),
        .o_Segments      (seg),
        .o_Digits        (dig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: seg/dig got %b_%b expected %b_%b", tag,
                     obs[11:4], obs[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    // Reference: pick digit by index, look up enable (digit1 in bit3), decode.
    function automatic logic [11:0] model(input logic r, input logic [1:0] s,
                                          input logic [3:0] e, input logic dt,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] dd);
        logic [3:0] v [4];
        logic [7:0] sg;
        int         idx;
        v[0] = a; v[1] = b; v[2] = c; v[3] = dd;
        idx  = int'(s);
        if (r || !e[3 - idx]) return 12'h000;
        sg      = 8'h00;
        if (v[idx] < 4'd10) sg[6:0] = PAT[v[idx]];
        sg[7]   = dt && (idx == 1);
        return {sg, 4'(1 << idx)};
    endfunction

    // Inputs are already set; take one edge and compare 1 ns later.
    task automatic step(input string tag, input logic [11:0] exp);
        @(posedge clk);
        #1;
        chk(tag, {seg, dig}, exp);
    endtask

    initial begin
        logic [11:0] exp;
        rst = 1'b1; sel = 2'd0; en = 4'b0000; dot = 1'b0;
        d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0;
        #2;

        // Reset and disabled digit
        step("reset1", 12'h000);
        step("reset2", 12'h000);
        rst = 1'b0; en = 4'b0000; sel = 2'd0; d1 = 4'd1;
        step("disabled", 12'h000);

        // Full decode sweep on digit1
        en = 4'b1000; sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            d1 = 4'(i);
            step($sformatf("sweep%0d", i), {1'b0, PAT[i], 4'b0001});
        end
        d1 = 4'd10; step("blank10", {8'h00, 4'b0001});
        d1 = 4'd15; step("blank15", {8'h00, 4'b0001});

        // Per-digit select
        d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4;
        sel = 2'd0; en = 4'b1000; step("sel0", {8'b00000110, 4'b0001});
        sel = 2'd1; en = 4'b0100; step("sel1", {8'b01011011, 4'b0010});
        sel = 2'd2; en = 4'b0010; step("sel2", {8'b01001111, 4'b0100});
        sel = 2'd3; en = 4'b0001; step("sel3", {8'b01100110, 4'b1000});
        en = 4'b1111; d4 = 4'd9;  step("sel3_all", {8'b01101111, 4'b1000});
        en = 4'b0000;             step("sel3_none", 12'h000);

        // Dot
        dot = 1'b1; sel = 2'd1; en = 4'b0100; d2 = 4'd5;
        step("dot_dig2", {8'b11101101, 4'b0010});
        sel = 2'd0; en = 4'b1000; d1 = 4'd5;
        step("dot_dig1", {8'b01101101, 4'b0001});
        sel = 2'd1; en = 4'b0100; d2 = 4'd7; dot = 1'b0;
        step("dot_off", {8'b00000111, 4'b0010});
        dot = 1'b1;
        step("dot_on", {8'b10000111, 4'b0010});
        en = 4'b1011;
        step("dot_disabled", 12'h000);

        // Multiple enables
        dot = 1'b0; en = 4'b1100; sel = 2'd0; d1 = 4'd6;
        step("multi_en", {8'b01111101, 4'b0001});

        // Clock scan, then again with reset on the Select=2 cycle
        d1 = 4'd2; d2 = 4'd3; d3 = 4'd5; d4 = 4'd4; en = 4'b1111; dot = 1'b1;
        sel = 2'd0; step("scan0", {8'b01011011, 4'b0001});
        sel = 2'd1; step("scan1", {8'b11001111, 4'b0010});
        sel = 2'd2; step("scan2", {8'b01101101, 4'b0100});
        sel = 2'd3; step("scan3", {8'b01100110, 4'b1000});
        sel = 2'd0; step("rscan0", {8'b01011011, 4'b0001});
        sel = 2'd1; step("rscan1", {8'b11001111, 4'b0010});
        sel = 2'd2; rst = 1'b1; step("rscan2_rst", 12'h000);
        sel = 2'd3; rst = 1'b0; step("rscan3", {8'b01100110, 4'b1000});
        sel = 2'd0; step("rscan0b", {8'b01011011, 4'b0001});
        sel = 2'd1; step("rscan1b", {8'b11001111, 4'b0010});

        // Randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            sel = 2'($urandom);
            en  = 4'($urandom);
            dot = 1'($urandom);
            d1  = 4'($urandom); d2 = 4'($urandom);
            d3  = 4'($urandom); d4 = 4'($urandom);
            exp = model(rst, sel, en, dot, d1, d2, d3, d4);
            step("rand", exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
